// File: rtl/load_unit_pkg.sv
// Shared types for the load path: load operation codes, FSM states and the
// alignment rule applied before a bus read is issued.
package load_unit_pkg;

    localparam int LOAD_OP_WIDTH = 3;

    typedef enum logic [LOAD_OP_WIDTH-1:0] {
        LOAD_OP_LB  = 3'b000,
        LOAD_OP_LH  = 3'b001,
        LOAD_OP_LW  = 3'b010,
        LOAD_OP_LBU = 3'b100,
        LOAD_OP_LHU = 3'b101
    } load_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RESP  = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    // Halves need an even address, words need a word-aligned address.
    function automatic logic is_misaligned(input load_op_e op, input logic [1:0] offset);
        logic fault;
        fault = 1'b0;
        case (op)
            LOAD_OP_LH, LOAD_OP_LHU: fault = offset[0];
            LOAD_OP_LW:              fault = (offset != 2'b00);
            default:                 fault = 1'b0;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/load_unit_decoder.sv
// Maps funct3 (or an AMO read phase) onto a load operation code; reserved
// encodings fall back to a word load because they are trapped upstream.
module load_decoder
    import load_unit_pkg::*;
(
    input  logic [2:0]               funct3,
    input  logic                     amo_operation_load,
    output logic [LOAD_OP_WIDTH-1:0] load_op
);

    always_comb begin
        // NOTE: assign a default before the case so no path leaves load_op
        // unassigned; otherwise synthesis infers a latch.
        load_op = LOAD_OP_LW;
        if (!amo_operation_load) begin
            case (funct3)
                3'b000:  load_op = LOAD_OP_LB;
                3'b001:  load_op = LOAD_OP_LH;
                3'b100:  load_op = LOAD_OP_LBU;
                3'b101:  load_op = LOAD_OP_LHU;
                default: load_op = LOAD_OP_LW;
            endcase
        end
    end

endmodule

// File: rtl/load_unit.sv
// Multicycle load unit: one word-aligned read per load, byte/half/word
// extraction with sign or zero extension, and a registered result with done.
module load_unit
    import load_unit_pkg::*;
#(
    parameter int XLEN = 32  // only 32 is supported
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic            amo_operation_load,
    input  logic [XLEN-1:0] addr,
    output logic            busy,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            misaligned
);

    state_e                   state;
    state_e                   state_next;
    logic [LOAD_OP_WIDTH-1:0] dec_op_raw;
    load_op_e                 dec_op;
    load_op_e                 op_q;
    logic [1:0]               offset_q;
    logic                     accept;
    logic [7:0]               byte_sel;
    logic [15:0]              half_sel;
    logic [XLEN-1:0]          load_data;

    load_decoder u_decoder (
        .funct3             (funct3),
        .amo_operation_load (amo_operation_load),
        .load_op            (dec_op_raw)
    );

    assign dec_op = load_op_e'(dec_op_raw);
    assign accept = (state == ST_IDLE) && start;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (!resetn) state <= ST_IDLE;
        else         state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = is_misaligned(dec_op, addr[1:0]) ? ST_FAULT : ST_REQ;
            ST_REQ:   if (mem_ready) state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            ST_FAULT: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs decode straight from state, so an async reset drops them at once.
    always_comb begin
        busy       = (state != ST_IDLE);
        mem_valid  = (state == ST_REQ);
        done       = (state == ST_RESP) || (state == ST_FAULT);
        misaligned = (state == ST_FAULT);
    end

    always_comb begin
        byte_sel  = mem_rdata[{offset_q, 3'b000} +: 8];
        half_sel  = mem_rdata[{offset_q[1], 4'b0000} +: 16];
        load_data = mem_rdata;
        case (op_q)
            LOAD_OP_LB:  load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LOAD_OP_LBU: load_data = {{(XLEN-8){1'b0}}, byte_sel};
            LOAD_OP_LH:  load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            LOAD_OP_LHU: load_data = {{(XLEN-16){1'b0}}, half_sel};
            default:     load_data = mem_rdata;
        endcase
    end

    // Request context is captured on accept; result only moves on a real response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_q     <= LOAD_OP_LW;
            offset_q <= 2'b00;
            mem_addr <= '0;
            result   <= '0;
        end else begin
            if (accept) begin
                op_q     <= dec_op;
                offset_q <= addr[1:0];
                mem_addr <= {addr[XLEN-1:2], 2'b00};
            end
            if ((state == ST_REQ) && mem_ready) begin
                result <= load_data;
            end
        end
    end

endmodule
